// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined RISC-V immediate generator.
// Holds the opcode constants, the format enum and the XLEN legality check.
package imm_gen_pkg;

   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_IMM32    = 7'b0011011;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_I    = 3'd0,
      FMT_S    = 3'd1,
      FMT_B    = 3'd2,
      FMT_U    = 3'd3,
      FMT_J    = 3'd4,
      FMT_Z    = 3'd5,
      FMT_NONE = 3'd7
   } imm_fmt_e;

   function automatic bit xlen_legal(input int unsigned xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle of the immediate generator: instruction side in, decoded side out.
// slave is the generator's view, master is the view of whoever drives and consumes it.
interface imm_gen_pipe_if
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   imm_fmt_e         out_fmt;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  in_valid, in_instr, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
   );

   modport master (
      output in_valid, in_instr, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
   );
endinterface

// File: rtl/imm_extract.sv
// Combinational immediate decode: instruction -> extended immediate, format, legality.
// IMM_GEN_ZICSR_EN turns SYSTEM funct3 101/110/111 into zero-extended uimm (format Z).
module imm_extract
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output imm_fmt_e        fmt,
   output logic            illegal
);

   logic [31:0] imm32;

   always_comb begin
      imm32   = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      case (instr[6:0])
         OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_MISC_MEM: begin
            imm32 = {{20{instr[31]}}, instr[31:20]};
            fmt   = FMT_I;
         end
         OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
            if (instr[14] && (instr[13:12] != 2'b00)) begin
               imm32 = {27'd0, instr[19:15]};
               fmt   = FMT_Z;
            end else begin
               imm32 = {{20{instr[31]}}, instr[31:20]};
               fmt   = FMT_I;
            end
`else
            imm32 = {{20{instr[31]}}, instr[31:20]};
            fmt   = FMT_I;
`endif
         end
         OP_STORE: begin
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            fmt   = FMT_S;
         end
         OP_BRANCH: begin
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            fmt   = FMT_B;
         end
         OP_LUI, OP_AUIPC: begin
            imm32 = {instr[31:12], 12'd0};
            fmt   = FMT_U;
         end
         OP_JAL: begin
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            fmt   = FMT_J;
         end
         default: illegal = 1'b1;
      endcase
   end

   // Every 32-bit result is already sign-correct (Z is zero-extended), so widening copies bit 31.
   if (XLEN > 32) begin : g_wide
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
   end else begin : g_narrow
      assign imm = imm32;
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, 2-entry skid buffer, saturating illegal counter.
// Optional IMM_GEN_ZICSR_EN enables CSR uimm decode in imm_extract.
//
//   state | meaning
//   EMPTY | no entry held, out_valid low
//   ONE   | head entry presented, skid slot free
//   TWO   | head presented, skid slot full, in_ready low
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 8,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   imm_gen_pipe_if.slave     bus,
   output logic [CNT_W-1:0]  illegal_cnt
);

   if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      imm_fmt_e         fmt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

   localparam entry_t RESET_ENTRY = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};

   occ_e            state;
   entry_t          head;
   entry_t          skid;
   entry_t          new_entry;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [XLEN-1:0] dec_imm;
   imm_fmt_e        dec_fmt;
   logic            dec_illegal;
   logic            push;
   logic            pop;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (bus.in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   always_comb begin
      new_entry         = RESET_ENTRY;
      new_entry.imm     = dec_imm;
      new_entry.fmt     = dec_fmt;
      new_entry.illegal = dec_illegal;
      new_entry.tag     = bus.in_tag;
   end

   assign push = bus.in_valid & in_ready_q;
   assign pop  = out_valid_q & bus.out_ready;

   // in_ready and out_valid are kept as flops next to the state so both ports stay registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= EMPTY;
         head        <= RESET_ENTRY;
         skid        <= RESET_ENTRY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         illegal_cnt <= '0;
      end else if (flush) begin
         state       <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         if (pop && head.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
         end
         case (state)
            EMPTY: begin
               if (push) begin
                  head        <= new_entry;
                  state       <= ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ONE: begin
               case ({push, pop})
                  2'b10: begin
                     skid       <= new_entry;
                     state      <= TWO;
                     in_ready_q <= 1'b0;
                  end
                  2'b01: begin
                     state       <= EMPTY;
                     out_valid_q <= 1'b0;
                  end
                  2'b11: head <= new_entry;
                  default: ;
               endcase
            end
            TWO: begin
               if (pop) begin
                  head       <= skid;
                  state      <= ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state       <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_imm     = head.imm;
   assign bus.out_fmt     = head.fmt;
   assign bus.out_illegal = head.illegal;
   assign bus.out_tag     = head.tag;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised RISC-V immediate generator for the decode stage. Decodes the immediate of every base-ISA format (I, S, B, U, J, optionally CSR zero-extended uimm) from a 32-bit instruction, sign-extends to XLEN, and tags format and legality. Sits between fetch/instruction register and the ID/EX register, with valid/ready handshakes on both sides and a 2-entry skid buffer so `in_ready` is registered.

## Interface
- `XLEN`, 64, datapath width; legal values 32 or 64 only.
- `TAG_W`, 8, width of the opaque sideband tag carried alongside each instruction (PC index, ROB id).
- `CNT_W`, 16, width of the saturating illegal-opcode counter.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  block can accept; registered (derived from occupancy state only).
- `in_instr`  in  32  raw instruction.
- `in_tag`  in  TAG_W  sideband tag.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts.
- `out_imm`  out  XLEN  extended immediate.
- `out_fmt`  out  3  format code (`imm_fmt_e`).
- `out_illegal`  out  1  opcode not recognised.
- `out_tag`  out  TAG_W  tag of the instruction on `out_imm`.
- `illegal_cnt`  out  CNT_W  count of illegal results delivered.

## Operation
- Opcode `instr[6:0]` selects format:
  - I: 0000011, 0010011, 0011011, 1100111, 0001111, 1110011 → `instr[31:20]` sign-extended. Shift immediates pass through raw; funct7 bits are not masked.
  - S: 0100011 → `{instr[31:25],instr[11:7]}` sign-extended.
  - B: 1100011 → `{instr[31],instr[7],instr[30:25],instr[11:8],1'b0}` sign-extended.
  - U: 0110111, 0010111 → `{instr[31:12],12'b0}`. XLEN=64 sign-extends from bit 31; XLEN=32 has no extension.
  - J: 1101111 → `{instr[31],instr[19:12],instr[20],instr[30:21],1'b0}` sign-extended.
  - Any other opcode → `out_imm`=0, `out_fmt`=NONE, `out_illegal`=1.
- Format codes: I=0, S=1, B=2, U=3, J=4, Z=5, NONE=7.
- Buffer occupancy FSM has states EMPTY, ONE, TWO. Entries are stored already decoded. The output presents the oldest entry.
  - EMPTY: accept → ONE.
  - ONE: accept without drain → TWO; drain without accept → EMPTY; both → ONE.
  - TWO: `in_ready`=0; drain → ONE.
- `in_ready` = (state != TWO).
- `illegal_cnt` increments on each output handshake (`out_valid & out_ready`) with `out_illegal`=1. It saturates at all-ones and never wraps.
- `flush`: next state EMPTY. An input handshake in the same cycle is discarded, as is an output handshake. Counter is not incremented by a flushed-same-cycle delivery. `flush` has priority over all other events.

## Timing
- Latency 1: an instruction accepted at edge N is visible on outputs after edge N, provided the buffer is empty or draining.
- Throughput 1 instruction/cycle with `out_ready` held high.
- Ordering is strictly FIFO; no entry is dropped or duplicated under backpressure.
- Outputs are stable while `out_valid & !out_ready`.
- Reset values (asynchronous, while `reset_n`=0):
  - `out_valid`=0, `out_imm`=0, `out_fmt`=NONE, `out_illegal`=0, `out_tag`=0, `illegal_cnt`=0.
  - State EMPTY, so `in_ready`=1.
- Reset asserted mid-transfer drops all buffered entries.

## Configuration
- `IMM_GEN_ZICSR_EN` defined: SYSTEM opcode (1110011) with funct3 ∈ {101,110,111} yields format Z, with `out_imm` = `instr[19:15]` zero-extended. Other SYSTEM funct3 values stay I.
- `IMM_GEN_ZICSR_EN` undefined: all SYSTEM opcodes are I-type. Code Z is never produced.

## Structure
- Package `imm_gen_pkg` holds the opcode constants, the `imm_fmt_e` 3-bit enum, and the XLEN-legal check.
- One combinational sub-module, `imm_extract`, maps (instr, XLEN) → (imm, fmt, illegal).
- The top level holds the skid buffer, occupancy FSM and counter.

## Test plan
- XLEN=64, one instruction at a time, `out_ready`=1:
  - 0xFFF00093 (addi x1,x0,-1) → imm 0xFFFFFFFFFFFFFFFF, fmt I, exactly 1-cycle latency.
  - 0xFE113C23 (sd x1,-8(x2)) → imm 0xFFFFFFFFFFFFFFF8, fmt S.
  - 0xFE000EE3 (beq -4) → imm 0xFFFFFFFFFFFFFFFC, fmt B.
- U/J and width:
  - 0x800000B7 (lui) → 0xFFFFFFFF80000000 at XLEN=64, and 0x80000000 at XLEN=32.
  - 0x0010006F (jal +2048) → 0x800, fmt J.
- Backpressure:
  - Hold `out_ready`=0 and offer tags 1,2,3 back-to-back → `in_ready` falls after tag 2 is accepted.
  - Release `out_ready` → tags 1,2,3 delivered in order, one per cycle, no loss.
- Illegal opcode:
  - 0x0000007F → imm 0, fmt NONE, illegal=1, counter +1.
  - With CNT_W=2, six illegal deliveries → `illegal_cnt` holds 3.
- Flush: buffer in state TWO, assert `flush` together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, counter unchanged, flushed tags never appear.
- Configuration: 0x300FD073 (csrrwi) → with `IMM_GEN_ZICSR_EN`, imm 0x1F, fmt Z; without it, imm 0x300, fmt I.
